relu_maxpool_2x2: RTL and testbench
===================================

Name: relu_maxpool_2x2

Overview:
- Peripheral stage directly downstream of the ReLU block.
- Consumes the ReLU int8 output stream in raster order, one pixel per valid cycle, and performs 2x2 stride-2 max pooling.
- Emits the pooled int8 stream to the GLB write path.
- A half-width line buffer holds the horizontal pair maxima of each even row until the matching odd row arrives.

Parameters:
- DATA_W, 8, pixel width (signed, two's complement).
- MAX_COLS, 64, maximum feature-map width; must be even.
- MAX_ROWS, 64, maximum feature-map height.
- CW, $clog2(MAX_COLS+1), column config/counter width (localparam).
- RW, $clog2(MAX_ROWS+1), row config/counter width (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; samples cfg_* and begins a frame.
- cfg_cols  in  CW  input frame width.
- cfg_rows  in  RW  input frame height.
- data_in  in  DATA_W  signed pixel from ReLU data_out.
- data_in_valid  in  1  from ReLU data_out_valid.
- data_out  out  DATA_W  signed pooled pixel.
- data_out_valid  out  1  data_out qualifier.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: data_out=0, data_out_valid=0, busy=0, done=0; all counters, h_reg and the state register are 0. Line buffer contents are don't-care.
- No backpressure. Every data_in_valid cycle in RUN consumes exactly one pixel; gaps between valids are allowed.
- State machine:
  - IDLE: on start, latch cfg_cols/cfg_rows, clear col/row counters, go to RUN. data_in_valid is ignored in IDLE.
  - RUN: busy=1. start is ignored. On valid with col=cfg_cols-1 and row=cfg_rows-1, go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE. start in DONE is ignored.
- Counters: col increments on each valid and wraps to 0 after cfg_cols-1. On wrap, row increments.
- Even row:
  - even col: h_reg <= data_in.
  - odd col: linebuf[col>>1] <= max(h_reg, data_in).
- Odd row:
  - even col: h_reg <= data_in.
  - odd col: data_out <= max(h_reg, data_in, linebuf[col>>1]) and data_out_valid <= 1.
- Latency: exactly 1 cycle, from the valid that carries the bottom-right pixel of a 2x2 window to data_out_valid. data_out_valid is 0 on every other cycle; data_out holds its last value.
- Comparisons are signed DATA_W with no width growth. On ties, the value is identical, so the source is irrelevant.
- Odd cfg_cols: the last column is consumed and counted but never pooled (floor). Odd cfg_rows: the last row is consumed but never pooled. The last even-row's linebuf writes are harmless.
- Output count per frame = floor(cols/2) * floor(rows/2).
- done asserts in the cycle after the final input pixel. This is the same cycle as the final output's data_out_valid when both dimensions are even.
- cfg_cols<2 or cfg_rows<2: the frame is still consumed and done still fires, with zero outputs. cfg values above MAX_* are illegal; behaviour is unspecified and flagged by a simulation assertion.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No done pulse. A partial window is discarded.

Decomposition:
- Shared package peripheral_pkg:
  - DATA_W.
  - MAX_COLS and MAX_ROWS defaults.
  - FSM state encoding: IDLE, RUN, DONE.
  - A signed-max function used by both compare stages.
- One sub-module, pool_line_buffer:
  - MAX_COLS/2 x DATA_W.
  - One synchronous write port; asynchronous read.
  - Implemented as a register array, so it maps to distributed RAM on the FPGA.

Test Plan:
- 4x4 frame, inputs 0..15 raster, continuous valid -> outputs 5,7,13,15. Each output is 1 cycle after inputs 5,7,13,15 respectively; done fires in the same cycle as output 15.
- 4x2 frame with random valid gaps (about 50% duty), pixels {9,1,3,8 / 2,7,6,4} -> outputs 9 then 8. No extra valids appear in gap cycles.
- 5x3 frame (odd cols and odd rows), inputs 1..15 -> single row of outputs 7,9. The 5th column and 3rd row produce nothing; done fires 1 cycle after pixel 15.
- Signed values -1,-128,-5,-2 in a 2x2 frame -> output -1. start pulsed during RUN is ignored, and cfg changes mid-frame have no effect.
- rst_n asserted after 6 pixels of an 8x8 frame -> outputs and busy go 0 immediately with no done pulse. A following 2x2 frame {1,2,3,4} -> output 4, then done.
- MAX_COLS x 2 frame -> MAX_COLS/2 outputs, with correct line buffer addressing at the top entry.

Source files
------------

// File: rtl/peripheral_pkg.sv
// Shared definitions for the post-ReLU peripheral stages: default widths,
// the frame FSM encoding and the signed maximum used by the pooling compares.
package peripheral_pkg;

  localparam int DATA_W   = 8;
  localparam int MAX_COLS = 64;
  localparam int MAX_ROWS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement max at the pixel width; no width growth.
  function automatic logic [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                             input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer holding the horizontal pair maxima of an even row.
// Register array with a synchronous write and a combinational read.
module pool_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// 2x2 stride-2 max pooling over a raster int8 stream from the ReLU stage.
// Even rows park pair maxima in the line buffer; odd rows complete the window.
module relu_maxpool_2x2 #(
  parameter int DATA_W   = peripheral_pkg::DATA_W,
  parameter int MAX_COLS = peripheral_pkg::MAX_COLS,
  parameter int MAX_ROWS = peripheral_pkg::MAX_ROWS,
  localparam int CW      = $clog2(MAX_COLS + 1),
  localparam int RW      = $clog2(MAX_ROWS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     cfg_cols,
  input  logic [RW-1:0]     cfg_rows,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              done
);

  import peripheral_pkg::*;

  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cols_reg, col_reg, last_col;
  logic [RW-1:0]     rows_reg, row_reg, last_row;
  logic [DATA_W-1:0] h_reg;
  logic              take, at_last_col, at_last_px;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_rdata, pair_max;

  // A zero dimension is treated like one so the frame still terminates.
  assign last_col    = (cols_reg == '0) ? '0 : cols_reg - 1'b1;
  assign last_row    = (rows_reg == '0) ? '0 : rows_reg - 1'b1;
  assign take        = (state_reg == RUN) && data_in_valid;
  assign at_last_col = (col_reg == last_col);
  assign at_last_px  = at_last_col && (row_reg == last_row);

  assign pair_max = smax(h_reg, data_in);
  assign lb_addr  = col_reg[LB_AW:1];
  assign lb_we    = take && col_reg[0] && !row_reg[0];

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH),
    .AW     (LB_AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (take && at_last_px) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cols_reg       <= '0;
      rows_reg       <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      h_reg          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_out_valid <= 1'b0;
      if (state_reg == IDLE && start) begin
        cols_reg <= cfg_cols;
        rows_reg <= cfg_rows;
        col_reg  <= '0;
        row_reg  <= '0;
      end else if (take) begin
        if (at_last_col) begin
          col_reg <= '0;
          row_reg <= row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
        // Odd-column pixels of odd rows close a 2x2 window.
        if (!col_reg[0]) begin
          h_reg <= data_in;
        end else if (row_reg[0]) begin
          data_out       <= smax(pair_max, lb_rdata);
          data_out_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == IDLE && start)
      assert (cfg_cols <= CW'(MAX_COLS) && cfg_rows <= RW'(MAX_ROWS))
        else $error("relu_maxpool_2x2: cfg exceeds MAX_COLS/MAX_ROWS");
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed and randomized frames checked against a window-max reference model.
module tb_relu_maxpool_2x2;

  localparam int DATA_W   = 8;
  localparam int MAX_COLS = 64;
  localparam int MAX_ROWS = 64;
  localparam int CW       = $clog2(MAX_COLS + 1);
  localparam int RW       = $clog2(MAX_ROWS + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CW-1:0]     cfg_cols;
  logic [RW-1:0]     cfg_rows;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              busy;
  logic              done;

  int total  = 0;
  int passed = 0;
  int frame_q[$];

  relu_maxpool_2x2 #(
    .DATA_W   (DATA_W),
    .MAX_COLS (MAX_COLS),
    .MAX_ROWS (MAX_ROWS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_cols       (cfg_cols),
    .cfg_rows       (cfg_rows),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: maximum of the four signed pixels of pooled window (wr, wc).
  function automatic int win_max(int cols, int wr, int wc);
    int m = -1000;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        int v = frame_q[(2*wr + dr)*cols + 2*wc + dc];
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic run_frame(input string name, input int cols, input int rows,
                           input int max_gap, input bit disturb);
    int seen = 0;
    cfg_cols = CW'(cols);
    cfg_rows = RW'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int  gaps   = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        bit  pooled = (r % 2 == 1) && (c % 2 == 1) && (r < (rows/2)*2) && (c < (cols/2)*2);
        bit  last   = (r == rows-1) && (c == cols-1);
        repeat (gaps) begin
          data_in_valid = 1'b0;
          @(posedge clk); #1;
          if (data_out_valid) seen++;
          check({name, "_gap_valid"}, data_out_valid, 0);
        end
        if (disturb && (r*cols + c == 1)) begin
          start    = 1'b1;
          cfg_cols = CW'(8);
          cfg_rows = RW'(8);
        end
        data_in       = DATA_W'(frame_q[r*cols + c]);
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        data_in_valid = 1'b0;
        if (data_out_valid) seen++;
        check({name, "_out_valid"}, data_out_valid, pooled);
        if (pooled) check({name, "_out_data"}, $signed(data_out), win_max(cols, r/2, c/2));
        check({name, "_done"}, done, last);
        check({name, "_busy"}, busy, !last);
      end
    end
    @(posedge clk); #1;
    if (data_out_valid) seen++;
    check({name, "_done_clear"}, done, 0);
    check({name, "_idle"}, busy, 0);
    check({name, "_out_count"}, seen, (cols/2)*(rows/2));
    $display("frame %s %0dx%0d outputs=%0d", name, cols, rows, seen);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_cols = '0; cfg_rows = '0;
    data_in = '0; data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", data_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Valids in IDLE must be ignored.
    data_in = 8'd100; data_in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_valid", data_out_valid, 0);
      check("idle_no_busy", busy, 0);
    end
    data_in_valid = 1'b0;

    frame_q = {};
    for (int i = 0; i < 16; i++) frame_q.push_back(i);
    run_frame("f4x4", 4, 4, 0, 1'b0);

    frame_q = {9, 1, 3, 8, 2, 7, 6, 4};
    run_frame("f4x2_gaps", 4, 2, 2, 1'b0);

    frame_q = {};
    for (int i = 1; i <= 15; i++) frame_q.push_back(i);
    run_frame("f5x3", 5, 3, 0, 1'b0);

    frame_q = {-1, -128, -5, -2};
    run_frame("f2x2_signed", 2, 2, 1, 1'b1);

    frame_q = {};
    for (int i = 0; i < 2*MAX_COLS; i++) frame_q.push_back(int'($urandom_range(0, 255)) - 128);
    run_frame("fmax_x2", MAX_COLS, 2, 0, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int cols = int'($urandom_range(1, 10));
      int rows = int'($urandom_range(1, 10));
      frame_q = {};
      for (int i = 0; i < cols*rows; i++) frame_q.push_back(int'($urandom_range(0, 255)) - 128);
      run_frame("frand", cols, rows, 2, 1'b0);
    end

    // Reset partway into an 8x8 frame.
    cfg_cols = CW'(8); cfg_rows = RW'(8); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_in = DATA_W'($urandom_range(0, 127)); data_in_valid = 1'b1;
      @(posedge clk); #1;
      check("mid_no_valid", data_out_valid, 0);
    end
    data_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_done", done, 0);
    $display("reset mid-frame applied");

    frame_q = {1, 2, 3, 4};
    run_frame("f2x2_after_rst", 2, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
